uart_reg_bridge: RTL and testbench

Parametrised UART-to-register bridge: the next-generation host debug link, with configurable register width, register count and read-only probe inputs. A host PC drives binary read/write frames over the board UART; the block updates a bank of control registers and returns read data or status. It sits in top level between the `uart_rxd`/`uart_txd` pins and user logic: switches, LEDs and datapath probes.

---
 rtl/uart_reg_bridge.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// UART-to-register bridge: binary read/write frames from a host update a bank of
// control registers and return read data (registers or read-only probes) or ACK/NAK.
module uart_reg_bridge #(
  parameter int unsigned       CLK_HZ       = 100_000_000,
  parameter int unsigned       BAUD         = 115200,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       NUM_REGS     = 8,
  parameter int unsigned       NUM_PROBES   = 4,
  parameter int unsigned       TIMEOUT_BITS = 32,
  parameter logic [DATA_W-1:0] RST_VAL      = '0
) (
  input  logic                           clk_100mhz,
  input  logic                           sys_rst_n,
  input  logic                           uart_rxd,
  output logic                           uart_txd,
  input  logic [NUM_PROBES*DATA_W-1:0]   probe_in,
  output logic [NUM_REGS*DATA_W-1:0]     ctrl_out,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic                           frame_err,
  output logic                           timeout_err,
  output logic                           busy
);

  localparam int unsigned DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned BC_W    = $clog2(NB + 1);
  localparam int unsigned TMO_CYC = TIMEOUT_BITS * DIV;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);

  // Single-byte responses are MSB-aligned so RESP can always shift out the top byte.
  localparam logic [DATA_W-1:0] ACK_WORD = DATA_W'(8'h06) << (DATA_W - 8);
  localparam logic [DATA_W-1:0] NAK_WORD = DATA_W'(8'h15) << (DATA_W - 8);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StExec, StResp} state_e;

  // RX engine state
  logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic             rx_active_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [3:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
  logic             rx_ferr_q;

  // TX engine state
  logic             txd_q;
  logic             tx_busy_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bits_q;
  logic [8:0]       tx_frame_q;
  logic             tx_ready;
  logic             tx_start;

  // Parser state
  state_e                     state_q;
  logic [7:0]                 cmd_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [BC_W-1:0]            wcnt_q;
  logic [TMO_W-1:0]           tmo_q;
  logic [DATA_W-1:0]          resp_q;
  logic [BC_W-1:0]            resp_left_q;
  logic [NUM_REGS*DATA_W-1:0] ctrl_q;
  logic [NUM_REGS-1:0]        wr_strobe_q;
  logic                       overrun_q;
  logic                       timeout_q;

  logic [31:0]       addr;
  logic              addr_is_reg;
  logic              addr_is_probe;
  logic [DATA_W-1:0] rd_word;

  assign addr          = {25'd0, cmd_q[6:0]};
  assign addr_is_reg   = addr < NUM_REGS;
  assign addr_is_probe = !addr_is_reg && (addr < NUM_REGS + NUM_PROBES);

  // TX can take a new byte when idle or in the final cycle of a stop bit (no inter-byte gap).
  assign tx_ready = !tx_busy_q || (tx_cnt_q == '0 && tx_bits_q == 4'd0);
  assign tx_start = (state_q == StResp) && (resp_left_q != '0) && tx_ready;

  // RX: synchronise, detect start edge, sample mid-bit, emit byte or framing error
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_ferr_q   <= 1'b0;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (!rx_active_q) begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= CNT_W'(DIV / 2 - 1);
          rx_bit_q    <= 4'd0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
      end else begin
        rx_cnt_q <= CNT_W'(DIV - 1);
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          // Start bit high at mid-bit: treat as a glitch.
          if (rxd_s2_q) rx_active_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_active_q <= 1'b0;
          if (rxd_s2_q) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_shift_q;
          end else begin
            rx_ferr_q <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  // TX: 8N1 shifter, start bit driven on the load edge
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bits_q  <= 4'd0;
      tx_frame_q <= 9'h1ff;
    end else if (tx_start) begin
      tx_busy_q  <= 1'b1;
      txd_q      <= 1'b0;
      tx_cnt_q   <= CNT_W'(DIV - 1);
      tx_bits_q  <= 4'd9;
      tx_frame_q <= {1'b1, resp_q[DATA_W-1 -: 8]};
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
      end else if (tx_bits_q != 4'd0) begin
        txd_q      <= tx_frame_q[0];
        tx_frame_q <= {1'b1, tx_frame_q[8:1]};
        tx_bits_q  <= tx_bits_q - 4'd1;
        tx_cnt_q   <= CNT_W'(DIV - 1);
      end else begin
        tx_busy_q <= 1'b0;
      end
    end
  end

  // Read mux over control registers and probe words
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (addr == k) rd_word = ctrl_q[k*DATA_W +: DATA_W];
    end
    for (int unsigned k = 0; k < NUM_PROBES; k++) begin
      if (addr == NUM_REGS + k) rd_word = probe_in[k*DATA_W +: DATA_W];
    end
  end

  // Parser FSM: command decode, write data collection, execute, response
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= 8'd0;
      wdata_q     <= '0;
      wcnt_q      <= '0;
      tmo_q       <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      ctrl_q      <= {NUM_REGS{RST_VAL}};
      wr_strobe_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      wr_strobe_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid_q) begin
            cmd_q   <= rx_data_q;
            state_q <= StCmd;
          end
        end
        StCmd: begin
          tmo_q   <= '0;
          wcnt_q  <= '0;
          state_q <= cmd_q[7] ? StWdata : StExec;
        end
        StWdata: begin
          if (rx_valid_q) begin
            wdata_q <= (wdata_q << 8) | DATA_W'(rx_data_q);
            wcnt_q  <= wcnt_q + BC_W'(1);
            tmo_q   <= '0;
            if (wcnt_q == BC_W'(NB - 1)) state_q <= StExec;
          end else if (tmo_q == TMO_W'(TMO_CYC)) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StExec: begin
          if (rx_valid_q) overrun_q <= 1'b1;
          if (cmd_q[7]) begin
            resp_left_q <= BC_W'(1);
            if (addr_is_reg) begin
              for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (addr == k) begin
                  ctrl_q[k*DATA_W +: DATA_W] <= wdata_q;
                  wr_strobe_q[k]             <= 1'b1;
                end
              end
              resp_q <= ACK_WORD;
            end else begin
              resp_q <= NAK_WORD;
            end
          end else if (addr_is_reg || addr_is_probe) begin
            resp_q      <= rd_word;
            resp_left_q <= BC_W'(NB);
          end else begin
            resp_q      <= NAK_WORD;
            resp_left_q <= BC_W'(1);
          end
          state_q <= StResp;
        end
        StResp: begin
          if (rx_valid_q) overrun_q <= 1'b1;
          if (tx_start) begin
            resp_q      <= resp_q << 8;
            resp_left_q <= resp_left_q - BC_W'(1);
          end else if (resp_left_q == '0 && !tx_busy_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_txd    = txd_q;
  assign ctrl_out    = ctrl_q;
  assign wr_strobe   = wr_strobe_q;
  assign frame_err   = rx_ferr_q | overrun_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Self-checking bench for uart_reg_bridge: host-side UART driver/receiver and a
// register-bank reference model computing expected responses and strobes.
module tb_uart_reg_bridge;

  localparam int unsigned DIV  = 10;
  localparam int unsigned NREG = 8;
  localparam int unsigned NPRB = 4;
  localparam int unsigned DW   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rxd = 1'b1;
  logic                 txd;
  logic [NPRB*DW-1:0]   probe = '0;
  logic [NREG*DW-1:0]   ctrl;
  logic [NREG-1:0]      strobe;
  logic                 ferr;
  logic                 terr;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_reg_bridge #(
    .CLK_HZ(100_000_000),
    .BAUD(10_000_000),
    .DATA_W(16),
    .NUM_REGS(8),
    .NUM_PROBES(4),
    .TIMEOUT_BITS(32),
    .RST_VAL(16'h0000)
  ) dut (
    .clk_100mhz(clk),
    .sys_rst_n(rst_n),
    .uart_rxd(rxd),
    .uart_txd(txd),
    .probe_in(probe),
    .ctrl_out(ctrl),
    .wr_strobe(strobe),
    .frame_err(ferr),
    .timeout_err(terr),
    .busy(busy)
  );

  // Reference model state
  logic [DW-1:0]   m_regs[NREG];
  logic [DW-1:0]   m_probe[NPRB];
  logic [7:0]      exp_q[$];
  logic [NREG-1:0] exp_strobe;

  // Monitor state
  int                 fe_cnt = 0;
  int                 to_cnt = 0;
  int                 tx_falls = 0;
  logic               txd_prev = 1'b1;
  logic [NREG*DW-1:0] ctrl_prev = '0;
  logic [NREG-1:0]    st_val[$];
  logic [NREG*DW-1:0] st_ctrl[$];
  logic [NREG*DW-1:0] st_prev[$];

  always @(negedge clk) begin
    if (ferr === 1'b1) fe_cnt++;
    if (terr === 1'b1) to_cnt++;
    if (txd_prev === 1'b1 && txd === 1'b0) tx_falls++;
    txd_prev = txd;
    if (strobe !== '0) begin
      st_val.push_back(strobe);
      st_ctrl.push_back(ctrl);
      st_prev.push_back(ctrl_prev);
    end
    ctrl_prev = ctrl;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void model(input logic [7:0] cmd, input logic [DW-1:0] data);
    int a;
    a = int'(cmd[6:0]);
    exp_q.delete();
    exp_strobe = '0;
    if (cmd[7]) begin
      if (a < NREG) begin
        m_regs[a]  = data;
        exp_strobe = NREG'(1) << a;
        exp_q.push_back(8'h06);
      end else begin
        exp_q.push_back(8'h15);
      end
    end else if (a < NREG) begin
      exp_q.push_back(m_regs[a][15:8]);
      exp_q.push_back(m_regs[a][7:0]);
    end else if (a < NREG + NPRB) begin
      exp_q.push_back(m_probe[a-NREG][15:8]);
      exp_q.push_back(m_probe[a-NREG][7:0]);
    end else begin
      exp_q.push_back(8'h15);
    end
  endfunction

  function automatic logic [NREG*DW-1:0] model_ctrl();
    logic [NREG*DW-1:0] v;
    for (int k = 0; k < NREG; k++) v[k*DW +: DW] = m_regs[k];
    return v;
  endfunction

  task automatic set_probe(input int k, input logic [DW-1:0] v);
    m_probe[k] = v;
    probe[k*DW +: DW] = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      repeat (DIV) @(posedge clk);
    end
  endtask

  // Waits up to max_wait cycles for a start bit, then samples mid-bit; returns at mid-stop.
  task automatic recv_byte(input int max_wait, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b = 8'h00;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (DIV / 2) @(negedge clk);
      if (txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic do_txn(input logic [7:0] cmd, input logic [DW-1:0] data, input string name);
    logic [7:0]         b;
    bit                 ok;
    int                 a;
    int                 n;
    int                 fe0;
    logic [DW-1:0]      old;
    logic [NREG*DW-1:0] t;
    logic [NREG*DW-1:0] tp;
    a = int'(cmd[6:0]);
    old = (a < NREG) ? m_regs[a] : '0;
    model(cmd, data);
    st_val.delete();
    st_ctrl.delete();
    st_prev.delete();
    fe0 = fe_cnt;
    send_byte(cmd, 1'b1);
    if (cmd[7]) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_in_wdata: got %b want 1", name, busy);
      end
      send_byte(data[15:8], 1'b1);
      send_byte(data[7:0], 1'b1);
    end
    foreach (exp_q[i]) begin
      recv_byte((i == 0) ? 40 : int'(DIV / 2), b, ok);
      checks++;
      if (!ok || b !== exp_q[i]) begin
        failures++;
        $display("FAIL %s resp_byte%0d: got %h (frame_ok=%0d) want %h", name, i, b, ok, exp_q[i]);
      end
    end
    repeat (DIV) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after: got %b want 0", name, busy);
    end
    n = (exp_strobe != '0) ? 1 : 0;
    checks++;
    if (st_val.size() != n || (n == 1 && st_val[0] !== exp_strobe)) begin
      failures++;
      $display("FAIL %s wr_strobe: got %0d pulses first=%h want %0d pulses of %h", name,
               st_val.size(), (st_val.size() > 0) ? st_val[0] : '0, n, exp_strobe);
    end else if (n == 1) begin
      t = st_ctrl[0];
      tp = st_prev[0];
      checks++;
      if (t[a*DW +: DW] !== data || tp[a*DW +: DW] !== old) begin
        failures++;
        $display("FAIL %s strobe_align: got new=%h prev=%h want new=%h prev=%h", name,
                 t[a*DW +: DW], tp[a*DW +: DW], data, old);
      end
    end
    checks++;
    if (ctrl !== model_ctrl()) begin
      failures++;
      $display("FAIL %s ctrl_out: got %h want %h", name, ctrl, model_ctrl());
    end
    checks++;
    if (fe_cnt != fe0) begin
      failures++;
      $display("FAIL %s spurious_frame_err: got %0d want %0d", name, fe_cnt, fe0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (txd !== 1'b1 || ctrl !== '0 || busy !== 1'b0 || strobe !== '0 ||
        ferr !== 1'b0 || terr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got txd=%b ctrl=%h busy=%b strobe=%h fe=%b to=%b want 1 0 0 0 0 0",
               txd, ctrl, busy, strobe, ferr, terr);
    end
    do_txn(8'h83, 16'hBEEF, "reset_write");
    checks++;
    if (ctrl[63:48] !== 16'hBEEF) begin
      failures++;
      $display("FAIL reset_write_word3: got %h want beef", ctrl[63:48]);
    end
  endtask

  task automatic test_probe_read();
    logic [7:0] b0, b1;
    bit ok0, ok1;
    set_probe(0, 16'h0F0F);
    set_probe(1, 16'h1234);
    set_probe(2, 16'hA5A5);
    set_probe(3, 16'h7E81);
    send_byte(8'h09, 1'b1);
    recv_byte(40, b0, ok0);
    set_probe(1, 16'hCDEF);
    recv_byte(DIV / 2, b1, ok1);
    checks++;
    if (!ok0 || b0 !== 8'h12) begin
      failures++;
      $display("FAIL probe_snapshot_hi: got %h (ok=%0d) want 12", b0, ok0);
    end
    checks++;
    if (!ok1 || b1 !== 8'h34) begin
      failures++;
      $display("FAIL probe_snapshot_lo: got %h (ok=%0d) want 34", b1, ok1);
    end
    repeat (DIV) @(negedge clk);
    do_txn(8'h09, 16'h0000, "probe_reread");
    do_txn(8'h0B, 16'h0000, "probe3_read");
  endtask

  task automatic test_illegal();
    do_txn(8'h8A, 16'h0001, "write_probe_nak");
    do_txn(8'h7F, 16'h0000, "read_oob_nak");
    do_txn(8'hFF, 16'h1357, "write_oob_nak");
  endtask

  task automatic test_timeout();
    int to0, tx0;
    do_txn(8'h81, 16'h5A5A, "timeout_setup");
    to0 = to_cnt;
    tx0 = tx_falls;
    send_byte(8'h81, 1'b1);
    send_byte(8'hAA, 1'b1);
    repeat (33 * DIV) @(negedge clk);
    checks++;
    if (to_cnt != to0 + 1) begin
      failures++;
      $display("FAIL timeout_pulse: got %0d pulses want 1", to_cnt - to0);
    end
    checks++;
    if (tx_falls != tx0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_quiet: got tx_starts=%0d busy=%b want 0 0", tx_falls - tx0, busy);
    end
    do_txn(8'h01, 16'h0000, "timeout_readback");
  endtask

  task automatic test_framing();
    int fe0, tx0;
    fe0 = fe_cnt;
    tx0 = tx_falls;
    send_byte(8'h55, 1'b0);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_stop: got fe_pulses=%0d busy=%b want 1 0", fe_cnt - fe0, busy);
    end
    fe0 = fe_cnt;
    @(posedge clk);
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 || busy !== 1'b0 || tx_falls != tx0) begin
      failures++;
      $display("FAIL glitch: got fe_pulses=%0d busy=%b tx_starts=%0d want 0 0 0",
               fe_cnt - fe0, busy, tx_falls - tx0);
    end
    do_txn(8'h03, 16'h0000, "after_framing_read");
  endtask

  task automatic test_overrun();
    int fe0;
    logic [7:0] exp0, exp1;
    model(8'h03, 16'h0000);
    exp0 = exp_q[0];
    exp1 = exp_q[1];
    fe0 = fe_cnt;
    send_byte(8'h03, 1'b1);
    fork
      send_byte(8'h01, 1'b1);
      begin
        logic [7:0] b0, b1;
        bit ok0, ok1;
        recv_byte(40, b0, ok0);
        recv_byte(DIV / 2, b1, ok1);
        checks++;
        if (!ok0 || !ok1 || b0 !== exp0 || b1 !== exp1) begin
          failures++;
          $display("FAIL overrun_resp: got %h %h (ok=%0d%0d) want %h %h",
                   b0, b1, ok0, ok1, exp0, exp1);
        end
      end
    join
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (fe_cnt != fe0 + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_err: got fe_pulses=%0d busy=%b want 1 0", fe_cnt - fe0, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0]    cmd;
    logic [6:0]    a;
    logic [DW-1:0] d;
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < NPRB; k++) set_probe(k, DW'($urandom));
      if ($urandom_range(0, 9) < 9) a = 7'($urandom_range(0, 13));
      else a = 7'($urandom_range(14, 127));
      cmd = {1'($urandom_range(0, 1)), a};
      d = DW'($urandom);
      do_txn(cmd, d, $sformatf("random%0d_cmd%h", n, cmd));
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 1'b0;
    send_byte(8'h03, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midreset_tx_start: got no start bit want start bit");
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || ctrl !== '0 || busy !== 1'b0 || strobe !== '0) begin
      failures++;
      $display("FAIL midreset_state: got txd=%b ctrl=%h busy=%b strobe=%h want 1 0 0 0",
               txd, ctrl, busy, strobe);
    end
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(8'h85, 16'hC0DE, "post_reset_write");
    do_txn(8'h05, 16'h0000, "post_reset_read5");
    do_txn(8'h03, 16'h0000, "post_reset_read3");
  endtask

  initial begin
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    for (int k = 0; k < NPRB; k++) m_probe[k] = '0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_probe_read();
    test_illegal();
    test_timeout();
    test_framing();
    test_overrun();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
